// File: rtl/fir_out_level_meter.sv
// Requantizes the bandstop filter output to OUT_WIDTH bits (round-half-up, saturating)
// and reports energy and peak magnitude of the requantized stream per WIN_LEN-sample window.
//
// state  | meaning
// SETTLE | discarding filter-fill samples after reset/clr
// ACCUM  | accumulating energy and peak over the current window
module fir_out_level_meter #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int WIN_LEN   = 256,
  parameter int SETTLE    = 51,
  localparam int E_WIDTH  = 2*OUT_WIDTH + $clog2(WIN_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  y_in,
  output logic signed [OUT_WIDTH-1:0] y_q,
  output logic                        y_q_valid,
  output logic                        sat_flag,
  output logic [E_WIDTH-1:0]          energy,
  output logic [OUT_WIDTH-1:0]        peak,
  output logic                        meas_valid
);

  localparam int CNT_W = $clog2(((SETTLE > WIN_LEN) ? SETTLE : WIN_LEN) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] WIN_LD    = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_RST   = (SETTLE > 0) ? SETTLE_LD : WIN_LD;
  localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [OUT_WIDTH-1:0] Q_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] Q_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {S_SETTLE, S_ACCUM} state_t;
  localparam state_t RST_STATE = (SETTLE > 0) ? S_SETTLE : S_ACCUM;

  // One extra bit of headroom keeps the rounding add from wrapping.
  logic signed [IN_WIDTH:0]    rnd_sum;
  logic signed [IN_WIDTH:0]    rnd_shr;
  logic                        sat_hi;
  logic                        sat_lo;
  logic signed [OUT_WIDTH-1:0] q_nxt;

  always_comb begin
    rnd_sum = {y_in[IN_WIDTH-1], y_in} + HALF;
    rnd_shr = rnd_sum >>> SHIFT;
    sat_hi  = !rnd_shr[IN_WIDTH] && (|rnd_shr[IN_WIDTH-1:OUT_WIDTH-1]);
    sat_lo  = rnd_shr[IN_WIDTH] && !(&rnd_shr[IN_WIDTH-1:OUT_WIDTH-1]);
    if (sat_hi)      q_nxt = Q_MAX;
    else if (sat_lo) q_nxt = Q_MIN;
    else             q_nxt = rnd_shr[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_q_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      y_q_valid <= in_valid;
      if (in_valid) y_q <= q_nxt;
      if (clr)                             sat_flag <= 1'b0;
      else if (in_valid && (sat_hi || sat_lo)) sat_flag <= 1'b1;
    end
  end

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [E_WIDTH-1:0]          acc_e, acc_e_nxt, energy_nxt, acc_e_sum;
  logic [OUT_WIDTH-1:0]        acc_p, acc_p_nxt, peak_nxt, acc_p_max, mag;
  logic signed [2*OUT_WIDTH-1:0] sq;
  logic                        meas_nxt;

  // |Q_MIN| does not fit, so it is clamped to Q_MAX.
  always_comb begin
    sq = y_q * y_q;
    if (y_q == Q_MIN)  mag = Q_MAX;
    else if (y_q[OUT_WIDTH-1]) mag = -y_q;
    else               mag = y_q;
    acc_e_sum = acc_e + E_WIDTH'(unsigned'(sq));
    acc_p_max = (mag > acc_p) ? mag : acc_p;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_e_nxt  = acc_e;
    acc_p_nxt  = acc_p;
    energy_nxt = energy;
    peak_nxt   = peak;
    meas_nxt   = 1'b0;
    if (clr) begin
      state_nxt = RST_STATE;
      cnt_nxt   = CNT_RST;
      acc_e_nxt = '0;
      acc_p_nxt = '0;
    end else if (y_q_valid) begin
      case (state)
        S_SETTLE: begin
          if (cnt == '0) begin
            state_nxt = S_ACCUM;
            cnt_nxt   = WIN_LD;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (cnt == '0) begin
            energy_nxt = acc_e_sum;
            peak_nxt   = acc_p_max;
            meas_nxt   = 1'b1;
            acc_e_nxt  = '0;
            acc_p_nxt  = '0;
            cnt_nxt    = WIN_LD;
          end else begin
            acc_e_nxt = acc_e_sum;
            acc_p_nxt = acc_p_max;
            cnt_nxt   = cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_STATE;
      cnt        <= CNT_RST;
      acc_e      <= '0;
      acc_p      <= '0;
      energy     <= '0;
      peak       <= '0;
      meas_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc_e      <= acc_e_nxt;
      acc_p      <= acc_p_nxt;
      energy     <= energy_nxt;
      peak       <= peak_nxt;
      meas_valid <= meas_nxt;
    end
  end

endmodule

// File: tb/tb_fir_out_level_meter.sv
// Bench for fir_out_level_meter: table vectors for requantization, directed window/reset/clr
// sequences, and random stimulus against a window-queue reference model.
module tb_fir_out_level_meter;
  localparam int SETTLE  = 51;
  localparam int WIN_LEN = 256;
  localparam int SHIFT   = 15;
  localparam longint QMAX = 32767;
  localparam longint QMIN = -32768;

  logic               clk = 1'b0;
  logic               rst, clr, in_valid;
  logic signed [37:0] y_in;
  logic signed [15:0] y_q;
  logic               y_q_valid, sat_flag, meas_valid;
  logic [39:0]        energy;
  logic [15:0]        peak;

  fir_out_level_meter dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .y_in(y_in),
    .y_q(y_q), .y_q_valid(y_q_valid), .sat_flag(sat_flag),
    .energy(energy), .peak(peak), .meas_valid(meas_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit     m_qv, m_sat, m_mv;
  longint m_q, m_e, m_p;
  int     settle_left;
  longint win[$];
  int     pulses;
  longint cap_e[$], cap_p[$];

  typedef struct { longint y; longint q; bit sat; } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint rq_raw(input longint y);
    return (y + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
  endfunction

  function automatic longint rq(input longint y);
    longint r = rq_raw(y);
    if (r > QMAX) return QMAX;
    if (r < QMIN) return QMIN;
    return r;
  endfunction

  task automatic model_reset();
    m_qv = 0; m_sat = 0; m_mv = 0; m_q = 0; m_e = 0; m_p = 0;
    settle_left = SETTLE;
    win.delete();
  endtask

  // One clock: model consumes the currently visible y_q, DUT edge, then compare.
  task automatic step(input bit v, input longint y, input bit c);
    longint r, a;
    m_mv = 0;
    if (c) begin
      settle_left = SETTLE;
      win.delete();
      m_sat = 0;
    end else if (m_qv) begin
      if (settle_left > 0) settle_left--;
      else begin
        win.push_back(m_q);
        if (win.size() == WIN_LEN) begin
          m_e = 0; m_p = 0;
          foreach (win[i]) begin
            m_e += win[i] * win[i];
            a = (win[i] < 0) ? -win[i] : win[i];
            if (a > QMAX) a = QMAX;
            if (a > m_p) m_p = a;
          end
          m_mv = 1;
          win.delete();
        end
      end
    end
    m_qv = v;
    if (v) begin
      r = rq_raw(y);
      m_q = rq(y);
      if (!c && (r > QMAX || r < QMIN)) m_sat = 1;
    end
    in_valid = v; y_in = y[37:0]; clr = c;
    @(posedge clk); #1;
    chk("y_q_valid", longint'(y_q_valid), longint'(m_qv));
    chk("y_q", longint'(y_q), m_q);
    chk("sat_flag", longint'(sat_flag), longint'(m_sat));
    chk("meas_valid", longint'(meas_valid), longint'(m_mv));
    chk("energy", longint'(energy), m_e);
    chk("peak", longint'(peak), m_p);
    if (meas_valid) begin
      pulses++;
      cap_e.push_back(longint'(energy));
      cap_p.push_back(longint'(peak));
    end
  endtask

  task automatic clear_caps();
    pulses = 0; cap_e.delete(); cap_p.delete();
  endtask

  initial begin
    int n, cyc;
    bit sgn;
    vecs[0] = '{3276800, 100, 0};
    vecs[1] = '{16384, 1, 0};
    vecs[2] = '{-16384, 0, 0};
    vecs[3] = '{-16385, -1, 0};
    vecs[4] = '{(longint'(1) << 37) - 1, 32767, 1};
    vecs[5] = '{-(longint'(1) << 37), -32768, 1};
    vecs[6] = '{0, 0, 1};

    rst = 1; clr = 0; in_valid = 0; y_in = '0;
    model_reset(); clear_caps();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y_q", longint'(y_q), 0);
    chk("rst_y_q_valid", longint'(y_q_valid), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_energy", longint'(energy), 0);
    chk("rst_peak", longint'(peak), 0);
    chk("rst_meas", longint'(meas_valid), 0);
    @(negedge clk); rst = 0;

    // requantization table
    for (int i = 0; i < 7; i++) begin
      step(1, vecs[i].y, 0);
      chk("tbl_y_q", longint'(y_q), vecs[i].q);
      chk("tbl_valid", longint'(y_q_valid), 1);
      chk("tbl_sat", longint'(sat_flag), longint'(vecs[i].sat));
    end
    step(0, 0, 1);
    chk("clr_sat", longint'(sat_flag), 0);

    // constant window: 51 settle + 256 counted samples of y_q = 100
    clear_caps();
    for (int i = 0; i < SETTLE + WIN_LEN; i++) step(1, 3276800, 0);
    chk("const_no_early", pulses, 0);
    step(0, 0, 0);
    chk("const_pulse", longint'(meas_valid), 1);
    chk("const_energy", longint'(energy), 2560000);
    chk("const_peak", longint'(peak), 100);
    step(0, 0, 0);
    chk("const_one_pulse", pulses, 1);

    // async reset mid-window (saturating sample first so sat_flag is set)
    step(1, (longint'(1) << 37) - 1, 0);
    for (int i = 0; i < 150; i++) step(1, 3276800, 0);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_y_q", longint'(y_q), 0);
    chk("arst_valid", longint'(y_q_valid), 0);
    chk("arst_sat", longint'(sat_flag), 0);
    chk("arst_energy", longint'(energy), 0);
    chk("arst_peak", longint'(peak), 0);
    chk("arst_meas", longint'(meas_valid), 0);
    @(negedge clk); rst = 0;
    model_reset(); clear_caps();
    for (int i = 0; i < SETTLE + WIN_LEN - 1; i++) step(1, 32768000, 0);
    chk("arst_no_early", pulses, 0);
    step(1, 32768000, 0);
    step(0, 0, 0);
    chk("arst_pulses", pulses, 1);
    if (cap_e.size() > 0) begin
      chk("arst_energy_win", cap_e[0], 256000000);
      chk("arst_peak_win", cap_p[0], 1000);
    end

    // clr coincident with a valid y_q: that sample is excluded, results retained
    clear_caps();
    step(1, 3276800, 0);
    step(1, 3276800, 1);
    chk("clr_keep_energy", longint'(energy), 256000000);
    chk("clr_keep_peak", longint'(peak), 1000);
    chk("clr_meas", longint'(meas_valid), 0);
    for (int i = 0; i < SETTLE + WIN_LEN - 1; i++) step(1, 3276800, 0);
    chk("clr_no_early", pulses, 0);
    step(0, 0, 0);
    chk("clr_pulse", pulses, 1);
    chk("clr_energy", longint'(energy), 2560000);

    // alternating +-1000 with every third cycle idle, then a window of zeros
    step(0, 0, 1);
    clear_caps();
    n = 0; cyc = 0; sgn = 1;
    while (n < SETTLE + WIN_LEN) begin
      cyc++;
      if (cyc % 3 == 0) step(0, 0, 0);
      else begin
        step(1, sgn ? 32768000 : -32768000, 0);
        sgn = !sgn;
        n++;
      end
    end
    for (int i = 0; i < WIN_LEN; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("alt_pulses", pulses, 2);
    if (cap_e.size() == 2) begin
      chk("alt_energy", cap_e[0], 256000000);
      chk("alt_peak", cap_p[0], 1000);
      chk("zero_energy", cap_e[1], 0);
      chk("zero_peak", cap_p[1], 0);
    end

    // random stimulus against the model
    clear_caps();
    for (int i = 0; i < 3000; i++) begin
      logic signed [37:0] t;
      longint y;
      bit v, c;
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) begin
        t = 38'({$urandom(), $urandom()});
        y = longint'(t);
      end else begin
        y = longint'($signed($urandom())) >>> ($urandom_range(0, 1) ? 2 : 5);
      end
      step(v, y, c);
    end
    chk("rand_saw_windows", longint'(pulses > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_out_level_meter.md
Name: fir_out_level_meter

Overview:
- Downstream stage of fir_bandstop_51; consumes its 38-bit y_out.
- Requantizes y_out to a 16-bit sample stream using round-half-up and saturation.
- Measures windowed energy and peak magnitude of that stream, giving a hardware readout of stopband attenuation at F0 = 50 kHz versus passband tones (20/80/100 kHz).

Parameters:
- IN_WIDTH, 38, width of y_in (filter output).
- OUT_WIDTH, 16, width of requantized sample y_q.
- SHIFT, 15, right shift undoing coefficient Q-format; range 1..IN_WIDTH-OUT_WIDTH.
- WIN_LEN, 256, samples per measurement window; power of two, ≥ 2.
- SETTLE, 51, valid samples discarded after reset/clr (filter fill); ≥ 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous restart of measurement.
- in_valid  in  1  y_in qualifier; one sample per high cycle.
- y_in  in  IN_WIDTH signed  filter output.
- y_q  out  OUT_WIDTH signed  requantized sample.
- y_q_valid  out  1  y_q qualifier.
- sat_flag  out  1  sticky: any requantized sample saturated.
- energy  out  2*OUT_WIDTH+log2(WIN_LEN) unsigned  sum of y_q² over last window (40 bits default).
- peak  out  OUT_WIDTH unsigned  max |y_q| over last window.
- meas_valid  out  1  one-cycle pulse when energy/peak update.

Behaviour:
- Reset:
  - rst high forces state = SETTLE and zeroes every output, counter and accumulator immediately, independent of clk.
  - Applies mid-window too: partial results are lost.
- Requant stage (1 cycle):
  - v = y_in + 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - If v > 2^(OUT_WIDTH-1)-1 → 32767; if v < -2^(OUT_WIDTH-1) → -32768; else truncate v to OUT_WIDTH.
  - Internal sum is IN_WIDTH+1 bits, so there is no wrap.
  - y_q and y_q_valid register on the edge after in_valid.
  - y_q_valid is exactly in_valid delayed 1 cycle; y_q holds its value while y_q_valid is low.
  - sat_flag sets on the edge where a saturated y_q is registered; it is cleared only by rst or clr.
- Measurement FSM, 2 states, advancing only on cycles with y_q_valid = 1 (gaps stall all counters):
  - SETTLE: count discarded samples. After SETTLE samples → ACCUM. If SETTLE = 0, enter ACCUM directly.
  - ACCUM:
    - acc_e += y_q*y_q (signed square, unsigned result).
    - acc_p = max(acc_p, |y_q|); |-32768| saturates to 32767.
    - Window counter increments per sample.
    - On the WIN_LEN-th sample, on the same edge: energy ← acc_e + y_q², peak ← max(acc_p, |y_q|), meas_valid = 1 for one cycle.
    - Also on that edge: acc_e, acc_p and the counter clear; the next valid sample starts a fresh window.
  - Latency: the WIN_LEN-th in_valid at cycle t produces meas_valid at cycle t+2.
  - energy and peak hold between pulses.
- clr:
  - Synchronous; returns FSM to SETTLE, clears counters, accumulators and sat_flag.
  - energy and peak keep their last values; meas_valid forced 0.
  - clr and y_q_valid in the same cycle: clr wins and that sample is not counted.
  - The requant path is unaffected by clr.
- Accumulator width is sufficient for WIN_LEN*(2^15)² with no overflow; no saturation is needed in acc_e.
- Back-to-back windows: no dead cycles. A sample in the cycle after meas_valid belongs to the new window.

Test Plan:
- Rounding, SHIFT=15:
  - y_in = 3276800 → y_q = 100
  - y_in = 16384 → 1
  - y_in = -16384 → 0
  - y_in = -16385 → -1
  - Each appears one cycle after in_valid, with y_q_valid aligned.
- Saturation:
  - y_in = 2^37-1 → y_q = 32767, sat_flag = 1 and stays 1.
  - y_in = -2^37 → -32768.
  - clr → sat_flag = 0.
- Constant window, SETTLE = 51, WIN_LEN = 256: 307 continuous samples with y_q = 100.
  - meas_valid pulses once, 2 cycles after sample 307.
  - energy = 2,560,000, peak = 100.
- Alternating y_q = ±1000 with in_valid deasserted every 3rd cycle:
  - energy = 256,000,000, peak = 1000.
  - The pulse lands 2 cycles after the 256th counted valid sample.
  - Next window: constant 0 → energy = 0, peak = 0, with no missed sample between windows.
- Reset and clr interruptions:
  - rst asserted asynchronously mid-window (e.g. sample 100 of ACCUM): all outputs 0 before the next edge, FSM in SETTLE; the first meas_valid after release needs 51+256 samples.
  - clr coincident with a valid sample: that sample is excluded, and energy/peak retain their prior values.
- Filter-in-loop: drive fir_bandstop_51 with 10000-amplitude sines at 20 kHz and 50 kHz, 5500 samples each.
  - energy(50 kHz) ≤ energy(20 kHz)/100, i.e. ≥ 20 dB stopband rejection.
  - No sat_flag.
